debug_memory_dumper: RTL
========================

Name: debug_memory_dumper

Overview:
- Initiator side of the MEMORY stage debug read port (i_debug_address -> o_data_debug_memory).
- On request from the debug unit, walks every data-memory word through that port, captures each word and streams it as bytes to the UART transmitter.
- Sits between the MEMORY stage debug port and the UART TX handshake. Runs only while the pipeline is halted or stepping, so there is no conflict with the load/store path.

Parameters:
- NB, 32, data word width (must be a multiple of 8).
- TAM, 16, number of data-memory words to dump.
- NB_ADDR, $clog2(TAM), width of the internal word counter.
- NB_BYTE, 8, UART byte width.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle request to dump memory; ignored unless IDLE.
- o_debug_address  out  NB  word index to MEMORY debug port, zero-extended from NB_ADDR.
- i_data_debug_memory  in  NB  word returned by MEMORY debug port.
- o_tx_data  out  NB_BYTE  byte to transmit.
- o_tx_start  out  1  one-cycle pulse: o_tx_data valid, UART begins sending.
- i_tx_done  in  1  one-cycle pulse from UART: previous byte finished.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset: state IDLE; word counter, byte counter and captured word are 0; all outputs are 0.
- FSM states: IDLE, ADDR, LATCH, SEND, WAIT_TX, NEXT, DONE.
- IDLE -> ADDR on i_start.
- ADDR: drive o_debug_address = counter for one cycle. This tolerates a 1-cycle registered read.
- LATCH: capture i_data_debug_memory into the word register; set byte counter = 0.
- SEND:
  - o_tx_data = byte[byte counter], MSB first (bits NB-1:NB-8 first).
  - Pulse o_tx_start for exactly this cycle, then go to WAIT_TX.
- WAIT_TX: hold o_tx_data stable and wait for i_tx_done.
  - On i_tx_done, if the byte counter is below NB/8-1: increment it and go to SEND.
  - Otherwise go to NEXT.
- NEXT:
  - If counter == TAM-1: go to DONE.
  - Otherwise increment the counter and go to ADDR.
- DONE: pulse o_done for one cycle, clear the counter, go to IDLE.
- i_tx_done is sampled only in WAIT_TX; the UART must not pulse it in the same cycle as o_tx_start. A stray i_tx_done in any other state is ignored.
- i_start in a non-IDLE state is ignored; it is neither queued nor restarts the dump.
- Byte stream: exactly TAM*NB/8 bytes (64 at defaults), in word order 0..TAM-1.
- Counter wrap: the counter never exceeds TAM-1; the NEXT compare prevents wrap.
- o_debug_address holds its last value outside ADDR/LATCH.
- Reset mid-dump: abort at the next edge and return to reset values. No partial-word completion and no o_done.
- Minimum cycles per byte: 2 + UART latency. Per-word overhead: 3 cycles (ADDR, LATCH, NEXT).

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of every transmitted byte is kept and cleared on i_start acceptance.
  - After the last word, NEXT goes to state CKSUM, which sends the XOR byte with the same SEND/WAIT_TX handshake and then goes to DONE.
  - Total bytes = TAM*NB/8 + 1.
- Not defined: no CKSUM state, no XOR register; NEXT goes directly to DONE.

Decomposition:
- Shared package/header (debug_constants.vh): state encodings, BYTES_PER_WORD = NB/8, checksum byte width.
- One natural sub-module: word_byte_serializer. It holds the captured word plus byte counter and presents the MSB-first byte select and a last-byte flag; it is reused by the register-file dumper.
- The FSM stays in debug_memory_dumper.

Test Plan:
- Preload words 0..15 with 32'h00000000+i*32'h01010101. Pulse i_start; UART model answers i_tx_done 5 cycles after each o_tx_start. Expect 64 bytes 00,00,00,00,01,01,01,01,...,0F,0F,0F,0F, then o_done once, then o_busy = 0.
- Word 4 = 32'hA5A5A5A5, word 8 = 32'h0000BEEF. Expect bytes 16-19 = A5 A5 A5 A5 and bytes 32-35 = 00 00 BE EF.
- Pulse i_start again during the dump, plus a stray i_tx_done in ADDR. Expect no restart, no skipped byte, byte count still 64.
- Assert i_reset after byte 10 is sent. Expect all outputs 0 next cycle and no o_done. A new i_start then restarts from word 0, byte 00.
- UART latency of 1 cycle (i_tx_done the cycle after start) versus 40 cycles. Expect an identical byte stream; o_tx_data stays stable throughout WAIT_TX.
- With DUMP_CHECKSUM_EN, memory all 32'h00000000 except word 0 = 32'h12345678. Expect byte 65 = 12^34^56^78 = 8'h08, then o_done.

Source files
------------

// File: rtl/debug_memory_dumper_pkg.sv
// Shared types and constants for the data-memory debug dumper.
// Build option: DUMP_CHECKSUM_EN appends an XOR checksum byte after the last word.
package debug_memory_dumper_pkg;

    localparam int DEF_NB         = 32;
    localparam int DEF_NB_BYTE    = 8;
    localparam int BYTES_PER_WORD = DEF_NB / DEF_NB_BYTE;
    localparam int NB_CKSUM       = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LATCH   = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
`ifdef DUMP_CHECKSUM_EN
        , ST_CKSUM = 3'd7
`endif
    } state_t;

    function automatic logic [NB_CKSUM-1:0] cksum_update(
        input logic [NB_CKSUM-1:0] acc,
        input logic [NB_CKSUM-1:0] data_byte
    );
        return acc ^ data_byte;
    endfunction

endpackage

// File: rtl/debug_memory_dumper_if.sv
// Debug-read and UART-TX handshake bundle; master is the dumper, slave is memory/UART/debug unit.
// Signal names keep the dumper-side direction prefixes of the original port list.
interface debug_memory_dumper_if #(
    parameter int NB      = 32,
    parameter int NB_BYTE = 8
);
    logic               i_start;
    logic [NB-1:0]      o_debug_address;
    logic [NB-1:0]      i_data_debug_memory;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_start;
    logic               i_tx_done;
    logic               o_busy;
    logic               o_done;

    modport master (
        input  i_start, i_data_debug_memory, i_tx_done,
        output o_debug_address, o_tx_data, o_tx_start, o_busy, o_done
    );

    modport slave (
        output i_start, i_data_debug_memory, i_tx_done,
        input  o_debug_address, o_tx_data, o_tx_start, o_busy, o_done
    );
endinterface

// File: rtl/debug_memory_dumper_word_byte_serializer.sv
// Holds one captured word and hands it out a byte at a time, MSB first.
// The top byte of the internal shift register is the byte currently presented.
module word_byte_serializer
    import debug_memory_dumper_pkg::*;
#(
    parameter int NB      = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    input  logic [NB-1:0]      load_word,
    output logic [NB_BYTE-1:0] byte_sel,
    output logic               last_byte
);
    localparam int BPW     = NB / NB_BYTE;
    localparam int NB_BCNT = (BPW > 1) ? $clog2(BPW) : 1;

    logic [NB-1:0]      word_r;
    logic [NB_BCNT-1:0] bcnt_r;

    // Capture a new word or shift the next byte into the top position.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r <= {NB{1'b0}};
            bcnt_r <= {NB_BCNT{1'b0}};
        end else if (load) begin
            word_r <= load_word;
            bcnt_r <= {NB_BCNT{1'b0}};
        end else if (advance) begin
            word_r <= word_r << NB_BYTE;
            bcnt_r <= bcnt_r + NB_BCNT'(1);
        end else begin
            word_r <= word_r;
            bcnt_r <= bcnt_r;
        end
    end

    assign byte_sel  = word_r[NB-1 -: NB_BYTE];
    assign last_byte = (bcnt_r == NB_BCNT'(BPW - 1));

endmodule

// File: rtl/debug_memory_dumper.sv
// Walks every data-memory word through the MEMORY debug read port and streams it to the UART.
// Build option: DUMP_CHECKSUM_EN sends a trailing XOR of all data bytes before finishing.
module debug_memory_dumper
    import debug_memory_dumper_pkg::*;
#(
    parameter int NB      = 32,
    parameter int TAM     = 16,
    parameter int NB_ADDR = $clog2(TAM),
    parameter int NB_BYTE = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    debug_memory_dumper_if.master bus
);
    state_t             state_r;
    logic [NB_ADDR-1:0] cnt_r;
    logic [NB-1:0]      addr_r;
    logic               tx_start_r;
    logic               busy_r;
    logic               done_r;

    logic               ser_load_s;
    logic               ser_advance_s;
    logic [NB-1:0]      ser_word_s;
    logic [NB_BYTE-1:0] ser_byte_s;
    logic               ser_last_s;
    logic               final_phase_s;

`ifdef DUMP_CHECKSUM_EN
    logic [NB_CKSUM-1:0] cksum_r;
    logic                cksum_phase_r;
    assign final_phase_s = cksum_phase_r;
`else
    assign final_phase_s = 1'b0;
`endif

    word_byte_serializer #(
        .NB      (NB),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .clk       (i_clk),
        .reset     (i_reset),
        .load      (ser_load_s),
        .advance   (ser_advance_s),
        .load_word (ser_word_s),
        .byte_sel  (ser_byte_s),
        .last_byte (ser_last_s)
    );

    // Serializer strobes follow the current state; memory data is valid during LATCH.
    always_comb begin
        ser_load_s    = 1'b0;
        ser_advance_s = 1'b0;
        ser_word_s    = bus.i_data_debug_memory;
        case (state_r)
            ST_LATCH: begin
                ser_load_s = 1'b1;
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CKSUM: begin
                ser_load_s = 1'b1;
                ser_word_s = NB'(cksum_r) << (NB - NB_CKSUM);
            end
`endif
            ST_WAIT_TX: begin
                if (bus.i_tx_done && !ser_last_s && !final_phase_s) begin
                    ser_advance_s = 1'b1;
                end else begin
                    ser_advance_s = 1'b0;
                end
            end
            default: begin
                ser_load_s    = 1'b0;
                ser_advance_s = 1'b0;
            end
        endcase
    end

    // Dump sequencer; every output is registered on entry to the state that owns it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {NB_ADDR{1'b0}};
            addr_r     <= {NB{1'b0}};
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            cksum_r       <= {NB_CKSUM{1'b0}};
            cksum_phase_r <= 1'b0;
`endif
        end else begin
            tx_start_r <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state_r <= ST_ADDR;
                        cnt_r   <= {NB_ADDR{1'b0}};
                        addr_r  <= {NB{1'b0}};
                        busy_r  <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        cksum_r       <= {NB_CKSUM{1'b0}};
                        cksum_phase_r <= 1'b0;
`endif
                    end
                end
                ST_ADDR: begin
                    state_r <= ST_LATCH;
                end
                ST_LATCH: begin
                    state_r    <= ST_SEND;
                    tx_start_r <= 1'b1;
                end
                ST_SEND: begin
                    state_r <= ST_WAIT_TX;
`ifdef DUMP_CHECKSUM_EN
                    if (!cksum_phase_r) begin
                        cksum_r <= cksum_update(cksum_r, ser_byte_s);
                    end
`endif
                end
                ST_WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        if (final_phase_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else if (!ser_last_s) begin
                            state_r    <= ST_SEND;
                            tx_start_r <= 1'b1;
                        end else begin
                            state_r <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    // Stop at the last word so the counter never wraps.
                    if (cnt_r == NB_ADDR'(TAM - 1)) begin
`ifdef DUMP_CHECKSUM_EN
                        state_r       <= ST_CKSUM;
                        cksum_phase_r <= 1'b1;
`else
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
`endif
                    end else begin
                        state_r <= ST_ADDR;
                        cnt_r   <= cnt_r + NB_ADDR'(1);
                        addr_r  <= NB'(cnt_r + NB_ADDR'(1));
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                ST_CKSUM: begin
                    state_r    <= ST_SEND;
                    tx_start_r <= 1'b1;
                end
`endif
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {NB_ADDR{1'b0}};
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_debug_address = addr_r;
    assign bus.o_tx_data       = ser_byte_s;
    assign bus.o_tx_start      = tx_start_r;
    assign bus.o_busy          = busy_r;
    assign bus.o_done          = done_r;

endmodule
